// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int PC_STEP = 4;
    localparam int WORD_W  = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Flush wins over push; the head reads as zero while empty.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: PC register, run/drain FSM and fetch decision
// feeding a small FIFO toward decode.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_a,
    input  logic [31:0]       imem_rd,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = WORD_W + ADDR_W;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              busy_q;
    logic [CW-1:0]     count;
    logic [FW-1:0]     head;
    logic              pop;
    logic              fetch;
    logic              drain_done;
    logic [ADDR_W-1:0] target;

    assign imem_a      = pc;
    assign busy        = busy_q;
    assign instr_valid = (count != '0);
    assign instr       = head[FW-1:ADDR_W];
    assign instr_pc    = head[ADDR_W-1:0];
    assign pop         = instr_valid && instr_ready;
    assign target      = redirect_pc & ~ADDR_W'(3);
    assign drain_done  = (count - CW'(pop)) == '0;

    assign fetch = (state == RUN) && !halt && !redirect_valid
                && ((count < CW'(DEPTH)) || pop);

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect_valid),
        .data  ({imem_rd, pc}),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            busy_q <= 1'b0;
        end else begin
            if (redirect_valid) pc <= target;
            else if (fetch)     pc <= pc + ADDR_W'(PC_STEP);

            unique case (state)
                IDLE: begin
                    if (start && !halt) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) state <= DRAIN;
                end
                DRAIN: begin
                    // A redirect flush empties the FIFO just like a final pop.
                    if (redirect_valid || drain_done) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: queue-level reference model,
// directed scenarios followed by random start/halt/redirect/ready.
module tb_imem_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents, mode (0 idle, 1 run, 2 drain), pc.
    logic [63:0] mq[$];
    logic [63:0] exp_q[$];
    int          m_mode = 0;
    logic [31:0] m_pc = '0;

    imem_fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Word at address a: 0x11, 0x22, 0x33 at 0, 4, 8 and so on.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    assign imem_rd = mem_f(imem_a);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h expected none",
                         instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_instr", instr, e[63:32]);
                chk("out_pc", instr_pc, e[31:0]);
            end
        end
    end

    task automatic cycle(input bit s, input bit h, input bit r,
                         input logic [31:0] rpc, input bit rdy);
        bit pop;
        bit fe;
        @(posedge clk);
        #1;
        chk("imem_a", imem_a, m_pc);
        chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
        chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
        if (mq.size() == 0) begin
            chk("empty_instr", instr, 32'd0);
            chk("empty_pc", instr_pc, 32'd0);
        end
        start          = s;
        halt           = h;
        redirect_valid = r;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        pop = (mq.size() != 0) && rdy;
        if (pop) begin
            exp_q.push_back(mq[0]);
            void'(mq.pop_front());
        end
        fe = (m_mode == 1) && !h && !r && (mq.size() < DEPTH);
        if (r) begin
            mq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else if (fe) begin
            mq.push_back({mem_f(m_pc), m_pc});
            m_pc = m_pc + 32'd4;
        end
        case (m_mode)
            0: if (s && !h) m_mode = 1;
            1: if (h) m_mode = 2;
            default: if (mq.size() == 0) m_mode = 0;
        endcase
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_a", imem_a, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        rst_n = 1'b1;

        // Start: valid two cycles later, then 0x11/0x22/0x33.
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("start_n1_valid", {31'd0, instr_valid}, 32'd0);
        chk("start_n1_busy", {31'd0, busy}, 32'd1);
        cycle(0, 0, 0, 0, 1);
        chk("start_n2_valid", {31'd0, instr_valid}, 32'd1);
        chk("start_n2_instr", instr, 32'h11);
        chk("start_n2_pc", instr_pc, 32'h0);
        repeat (3) cycle(0, 0, 0, 0, 1);

        // Backpressure from pc 0.
        cycle(0, 0, 1, 32'h0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0);
        chk("bp_imem_a", imem_a, 32'h8);
        chk("bp_valid", {31'd0, instr_valid}, 32'd1);
        cycle(0, 0, 0, 0, 1);
        chk("bp_head_pc", instr_pc, 32'h0);
        repeat (3) cycle(0, 0, 0, 0, 1);

        // Redirect with a full FIFO.
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0103, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rd_n1_valid", {31'd0, instr_valid}, 32'd0);
        chk("rd_n1_imem_a", imem_a, 32'h100);
        cycle(0, 0, 0, 0, 1);
        chk("rd_n2_valid", {31'd0, instr_valid}, 32'd1);
        chk("rd_n2_pc", instr_pc, 32'h100);
        cycle(0, 0, 0, 0, 1);

        // Halt with two entries queued, then resume.
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("halt_n1_busy", {31'd0, busy}, 32'd1);
        cycle(0, 0, 0, 0, 1);
        chk("halt_n2_busy", {31'd0, busy}, 32'd0);
        repeat (2) cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 0, 1);

        // Wrap past the top of the address space.
        cycle(0, 0, 1, 32'hFFFF_FFF8, 1);
        cycle(0, 0, 0, 0, 1);
        chk("wrap_imem_a", imem_a, 32'hFFFF_FFF8);
        cycle(0, 0, 0, 0, 1);
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        cycle(0, 0, 0, 0, 1);
        chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 1);
        chk("wrap_pc2", instr_pc, 32'h0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2;
        start          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_imem_a", imem_a, 32'h0);
        chk("arst_instr", instr, 32'd0);
        mq.delete();
        m_mode = 0;
        m_pc   = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom,
                  $urandom_range(0, 9) < 7);
        end
        cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
